// File: rtl/keystream_ctrl_pkg.sv
// Shared types and defaults for the keystream controller.
// The WARMUP state only exists when KEYSTREAM_WARMUP_EN is defined.
package keystream_ctrl_pkg;

  localparam int SEED_W_DEF = 80;
  localparam int BYTE_W     = 8;
  localparam int WARMUP_DEF = 160;
  localparam int BIT_IDX_W  = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
`ifdef KEYSTREAM_WARMUP_EN
    WARMUP = 3'd2,
`endif
    FILL   = 3'd3,
    HOLD   = 3'd4
  } state_e;

endpackage

// File: rtl/keystream_ctrl_packer.sv
// Serial-to-byte packer: bit k of the byte is taken from the k-th accepted bit.
// The index wraps 7->0 so every byte is built from eight fresh bits.
module ks_byte_packer
  import keystream_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic              bit_i,
  output logic [BYTE_W-1:0] byte_o,
  output logic              last_o
);

  logic [BIT_IDX_W-1:0] idx_q, idx_d;
  logic [BYTE_W-1:0]    bits_q, bits_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (shift_i) begin
      idx_d = idx_q + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BYTE_W; gi++) begin : g_bit
      assign bits_d[gi] = (shift_i && !clr_i && (idx_q == BIT_IDX_W'(gi))) ? bit_i : bits_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      bits_q <= '0;
    end else begin
      idx_q  <= idx_d;
      bits_q <= bits_d;
    end
  end

  assign byte_o = bits_q;
  assign last_o = (idx_q == BIT_IDX_W'(BYTE_W - 1));

endmodule

// File: rtl/keystream_ctrl.sv
// Keystream session controller: seeds an external NFSR, optionally discards
// warm-up shifts (KEYSTREAM_WARMUP_EN), then packs its output into handshaked bytes.
module keystream_ctrl
  import keystream_ctrl_pkg::*;
#(
  parameter int WARMUP_CYCLES = WARMUP_DEF,
  parameter int SEED_W        = SEED_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [SEED_W-1:0] seed,
  input  logic              ks_ready,
  output logic              ks_valid,
  output logic [BYTE_W-1:0] ks_byte,
  output logic              busy,
  output logic [15:0]       byte_cnt,
  output logic              nfsr_par_load,
  output logic              nfsr_shift_en,
  output logic [SEED_W-1:0] nfsr_seed,
  input  logic              nfsr_ser_out
);

  state_e              state_q, state_d;
  logic [SEED_W-1:0]   seed_q, seed_d;
  logic [15:0]         byte_cnt_q, byte_cnt_d;
  logic                ks_valid_q, ks_valid_d;
  logic [BYTE_W-1:0]   ks_byte_q, ks_byte_d;
  logic                busy_q, busy_d;
  logic                par_load_q, par_load_d;
  logic                shift_en_q, shift_en_d;
  logic                pk_clr, pk_shift, pk_last;
  logic [BYTE_W-1:0]   pk_byte;

`ifdef KEYSTREAM_WARMUP_EN
  localparam int WCNT_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  logic [WCNT_W-1:0] warm_cnt_q, warm_cnt_d;
`else
  logic unused_warmup;
  assign unused_warmup = (WARMUP_CYCLES != 0);
`endif

  ks_byte_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (pk_clr),
    .shift_i (pk_shift),
    .bit_i   (nfsr_ser_out),
    .byte_o  (pk_byte),
    .last_o  (pk_last)
  );

  always_comb begin
    state_d    = state_q;
    seed_d     = seed_q;
    byte_cnt_d = byte_cnt_q;
    ks_valid_d = ks_valid_q;
    ks_byte_d  = ks_byte_q;
    par_load_d = 1'b0;
    shift_en_d = 1'b0;
    pk_clr     = 1'b0;
    pk_shift   = 1'b0;
`ifdef KEYSTREAM_WARMUP_EN
    warm_cnt_d = warm_cnt_q;
`endif
    if (stop) begin
      state_d    = IDLE;
      ks_valid_d = 1'b0;
      pk_clr     = 1'b1;
`ifdef KEYSTREAM_WARMUP_EN
      warm_cnt_d = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            seed_d     = seed;
            byte_cnt_d = '0;
            par_load_d = 1'b1;
            pk_clr     = 1'b1;
            state_d    = LOAD;
          end
        end
        LOAD: begin
          shift_en_d = 1'b1;
`ifdef KEYSTREAM_WARMUP_EN
          warm_cnt_d = '0;
          state_d    = (WARMUP_CYCLES > 0) ? WARMUP : FILL;
`else
          state_d    = FILL;
`endif
        end
`ifdef KEYSTREAM_WARMUP_EN
        WARMUP: begin
          // Shift enable stays high across the WARMUP->FILL boundary.
          shift_en_d = 1'b1;
          if (warm_cnt_q == WCNT_W'(WARMUP_CYCLES - 1)) begin
            warm_cnt_d = '0;
            state_d    = FILL;
          end else begin
            warm_cnt_d = warm_cnt_q + 1'b1;
          end
        end
`endif
        FILL: begin
          pk_shift = 1'b1;
          if (pk_last) begin
            state_d = HOLD;
          end else begin
            shift_en_d = 1'b1;
          end
        end
        HOLD: begin
          // First HOLD cycle publishes the completed byte from the packer.
          if (!ks_valid_q) begin
            ks_valid_d = 1'b1;
            ks_byte_d  = pk_byte;
          end else if (ks_ready) begin
            ks_valid_d = 1'b0;
            byte_cnt_d = byte_cnt_q + 16'd1;
            shift_en_d = 1'b1;
            state_d    = FILL;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      seed_q     <= '0;
      byte_cnt_q <= '0;
      ks_valid_q <= 1'b0;
      ks_byte_q  <= '0;
      busy_q     <= 1'b0;
      par_load_q <= 1'b0;
      shift_en_q <= 1'b0;
`ifdef KEYSTREAM_WARMUP_EN
      warm_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      byte_cnt_q <= byte_cnt_d;
      ks_valid_q <= ks_valid_d;
      ks_byte_q  <= ks_byte_d;
      busy_q     <= busy_d;
      par_load_q <= par_load_d;
      shift_en_q <= shift_en_d;
`ifdef KEYSTREAM_WARMUP_EN
      warm_cnt_q <= warm_cnt_d;
`endif
    end
  end

  assign ks_valid      = ks_valid_q;
  assign ks_byte       = ks_byte_q;
  assign busy          = busy_q;
  assign byte_cnt      = byte_cnt_q;
  assign nfsr_par_load = par_load_q;
  assign nfsr_shift_en = shift_en_q;
  assign nfsr_seed     = seed_q;

endmodule

// File: tb/tb_keystream_ctrl.sv
// Self-checking bench for keystream_ctrl with an attached NFSR model and a
// byte scoreboard; latency expectations follow KEYSTREAM_WARMUP_EN.
module tb_keystream_ctrl;
  import keystream_ctrl_pkg::*;

  localparam int SW = 80;
`ifdef KEYSTREAM_WARMUP_EN
  localparam int WEFF = WARMUP_DEF;
`else
  localparam int WEFF = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [SW-1:0] seed = '0;
  logic          ks_ready = 1'b0;
  logic          ks_valid;
  logic [7:0]    ks_byte;
  logic          busy;
  logic [15:0]   byte_cnt;
  logic          nfsr_par_load;
  logic          nfsr_shift_en;
  logic [SW-1:0] nfsr_seed;
  logic          nfsr_ser_out;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [7:0]    exp_q[$];
  logic          force_mode = 1'b0;
  logic          force_bit = 1'b0;
  logic [SW-1:0] nf_q;

  keystream_ctrl #(.WARMUP_CYCLES(WARMUP_DEF), .SEED_W(SW)) dut (
    .clk           (clk),
    .rst           (rst_n),
    .start         (start),
    .stop          (stop),
    .seed          (seed),
    .ks_ready      (ks_ready),
    .ks_valid      (ks_valid),
    .ks_byte       (ks_byte),
    .busy          (busy),
    .byte_cnt      (byte_cnt),
    .nfsr_par_load (nfsr_par_load),
    .nfsr_shift_en (nfsr_shift_en),
    .nfsr_seed     (nfsr_seed),
    .nfsr_ser_out  (nfsr_ser_out)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] nf_step(input logic [SW-1:0] s);
    logic fb;
    fb = s[0] ^ s[13] ^ s[51] ^ (s[23] & s[38]);
    return {fb, s[SW-1:1]};
  endfunction

  // Reference NFSR driven by the controller's load/shift strobes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) nf_q <= '0;
    else if (nfsr_par_load) nf_q <= nfsr_seed;
    else if (nfsr_shift_en) nf_q <= nf_step(nf_q);
  end
  assign nfsr_ser_out = force_mode ? force_bit : nf_q[0];

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ref(input logic [SW-1:0] s0, input int nbytes);
    logic [SW-1:0] s;
    logic [7:0]    b;
    s = s0;
    repeat (WEFF) s = nf_step(s);
    for (int n = 0; n < nbytes; n++) begin
      for (int k = 0; k < 8; k++) begin
        b[k] = s[0];
        s = nf_step(s);
      end
      exp_q.push_back(b);
    end
  endtask

  // Drives the forced serial bits on the cycles the controller is expected to sample them.
  task automatic run_forced(input logic [7:0] pat, input int nbits);
    if (nbits == 8) exp_q.push_back(pat);
    start = 1'b1;
    tick();
    start = 1'b0;
    force_bit = 1'b0;
    repeat (WEFF + 1) tick();
    for (int k = 0; k < nbits; k++) begin
      force_bit = pat[k];
      tick();
    end
    if (nbits == 8) begin
      tick();
      chk("forced_valid", 80'(ks_valid), 80'(1'b1));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 80'(ks_valid), 80'(0));
    chk({tag, "_byte"}, 80'(ks_byte), 80'(0));
    chk({tag, "_busy"}, 80'(busy), 80'(0));
    chk({tag, "_cnt"}, 80'(byte_cnt), 80'(0));
    chk({tag, "_par"}, 80'(nfsr_par_load), 80'(0));
    chk({tag, "_shift"}, 80'(nfsr_shift_en), 80'(0));
    chk({tag, "_seed"}, nfsr_seed, 80'(0));
  endtask

  // Scoreboard: a byte is consumed on the edge following a negedge with valid&ready.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("par_shift_excl", 80'(nfsr_par_load & nfsr_shift_en), 80'(0));
      if (ks_valid && ks_ready) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_bad++;
          $error("FAIL unexpected_byte: observed %02h, expected none", ks_byte);
        end
        if (exp_q.size() != 0) chk("ks_byte", 80'(ks_byte), 80'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [SW-1:0] s1;
    logic [7:0]    b0;
    logic [15:0]   c0;
    int            waited;
    s1 = 80'hA5C3_1F00_DEAD_BEEF_1234;

    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // stop beats start in IDLE
    start = 1'b1; stop = 1'b1; seed = s1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("stop_wins_busy", 80'(busy), 80'(0));
    chk("stop_wins_par", 80'(nfsr_par_load), 80'(0));
    chk("stop_wins_seed", nfsr_seed, 80'(0));

    // NFSR-driven session
    push_ref(s1, 4);
    ks_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_par", 80'(nfsr_par_load), 80'(1));
    chk("load_shift", 80'(nfsr_shift_en), 80'(0));
    chk("load_busy", 80'(busy), 80'(1));
    chk("load_seed", nfsr_seed, s1);
    chk("load_cnt", 80'(byte_cnt), 80'(0));
    tick();
    chk("post_load_par", 80'(nfsr_par_load), 80'(0));
    chk("post_load_shift", 80'(nfsr_shift_en), 80'(1));
    waited = 1;
    while (!ks_valid && waited < WEFF + 40) begin
      tick();
      waited++;
    end
    chk("first_valid_latency", 80'(waited), 80'(WEFF + 10));

    waited = 0;
    while (byte_cnt != 16'd3 && waited < 100) begin
      tick();
      waited++;
    end
    chk("three_bytes_cnt", 80'(byte_cnt), 80'(3));

    // back-pressure in HOLD
    ks_ready = 1'b0;
    waited = 0;
    while (!ks_valid && waited < 40) begin
      tick();
      waited++;
    end
    chk("hold_entry_valid", 80'(ks_valid), 80'(1));
    b0 = ks_byte;
    c0 = byte_cnt;
    repeat (20) begin
      tick();
      chk("hold_byte", 80'(ks_byte), 80'(b0));
      chk("hold_shift", 80'(nfsr_shift_en), 80'(0));
      chk("hold_cnt", 80'(byte_cnt), 80'(c0));
      chk("hold_valid", 80'(ks_valid), 80'(1));
    end
    ks_ready = 1'b1;
    tick();
    chk("handshake_valid", 80'(ks_valid), 80'(0));
    chk("handshake_cnt", 80'(byte_cnt), 80'(c0 + 16'd1));
    ks_ready = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", 80'(busy), 80'(0));
    chk("stop_valid", 80'(ks_valid), 80'(0));
    chk("stop_shift", 80'(nfsr_shift_en), 80'(0));
    chk("stop_cnt_held", 80'(byte_cnt), 80'(c0 + 16'd1));
    chk("stop_seed_held", nfsr_seed, s1);
    chk("sb_drained_1", 80'(exp_q.size()), 80'(0));

    // forced pattern 1,0,0,0,0,0,0,1
    force_mode = 1'b1;
    ks_ready = 1'b1;
    run_forced(8'h81, 8);
    tick();
    chk("forced_cnt", 80'(byte_cnt), 80'(1));
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // abort at FILL bit 4, then restart from fresh bits
    run_forced(8'hFF, 4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("abort_busy", 80'(busy), 80'(0));
    repeat (12) begin
      tick();
      chk("abort_no_valid", 80'(ks_valid), 80'(0));
    end
    run_forced(8'h5A, 8);
    tick();
    chk("restart_cnt", 80'(byte_cnt), 80'(1));
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // asynchronous reset mid-session
    force_mode = 1'b0;
    ks_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat ((WEFF > 0) ? 49 : 4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_restart_par", 80'(nfsr_par_load), 80'(1));
    tick();
    chk("rst_restart_par_off", 80'(nfsr_par_load), 80'(0));
    chk("rst_restart_shift", 80'(nfsr_shift_en), 80'(1));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("sb_drained_2", 80'(exp_q.size()), 80'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
